// File: rtl/replacer_compact.sv
// replacer_compact
//   Run-length encoder for the replacer stream pair. Raw bytes are pulled from a
//   non-show-ahead input FIFO. Bytes equal to KEY are dropped and counted as replace
//   runs. All other bytes are forwarded to the vid FIFO and counted as literal groups.
//   Count bytes go to the cnt FIFO: bit7=1 replace run, bit7=0 literal group,
//   [6:0] = length 1..MAX_CNT.
//
// Ports
//   clk         clock
//   rst         asynchronous active-low reset
//   clk_en      clock enable; state and strobes frozen while low
//   data_in     raw byte, valid the cycle after data_rd
//   last_in     end-of-frame flag travelling with data_in
//   data_empty  input FIFO empty
//   data_rd     input FIFO read strobe (combinational)
//   vid_out     literal byte to the vid FIFO
//   vid_wr      vid FIFO write strobe
//   vid_afull   vid FIFO almost full
//   cnt_out     count byte to the cnt FIFO
//   cnt_wr      cnt FIFO write strobe
//   cnt_afull   cnt FIFO almost full
module replacer_compact #(
  parameter logic [7:0]  KEY     = 8'h00,
  parameter int unsigned MAX_CNT = 127
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] data_in,
  input  logic       last_in,
  input  logic       data_empty,
  output logic       data_rd,
  output logic [7:0] vid_out,
  output logic       vid_wr,
  input  logic       vid_afull,
  output logic [7:0] cnt_out,
  output logic       cnt_wr,
  input  logic       cnt_afull
);

  typedef enum logic [1:0] {IDLE = 2'd0, LIT = 2'd1, RUN = 2'd2} state_t;

  localparam logic [6:0] MAX_C = 7'(MAX_CNT);

  state_t     state_q, state_d;
  logic [6:0] count_q, count_d;
  logic       byte_valid_q;
  logic       pend_valid_q, pend_valid_d;
  logic [7:0] pend_q, pend_d;
  logic       vid_wr_q, vid_wr_d;
  logic [7:0] vid_out_q, vid_out_d;
  logic       cnt_wr_q, cnt_wr_d;
  logic [7:0] cnt_out_q, cnt_out_d;

  logic       is_key;
  state_t     mode;
  logic       emit;
  logic [7:0] emit_val;
  logic [6:0] count_new;

  // The extra cycle after a last byte (byte_valid & last_in) keeps the next frame's
  // first byte from being read while the flush decision is still pending; a queued
  // pend count blocks reads so the cnt strobe slot is free for it.
  assign data_rd = rst & clk_en & ~data_empty & ~vid_afull & ~cnt_afull
                 & ~pend_valid_q & ~(byte_valid_q & last_in);

  assign is_key = (data_in == KEY);
  assign mode   = is_key ? RUN : LIT;

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    vid_wr_d     = 1'b0;
    vid_out_d    = vid_out_q;
    cnt_wr_d     = 1'b0;
    cnt_out_d    = cnt_out_q;
    emit         = 1'b0;
    emit_val     = 8'h00;
    count_new    = count_q;

    if (pend_valid_q) begin
      // Reads are blocked while pend is held, so no byte competes for this slot.
      cnt_wr_d     = 1'b1;
      cnt_out_d    = pend_q;
      pend_valid_d = 1'b0;
    end else if (byte_valid_q) begin
      if (!is_key) begin
        vid_wr_d  = 1'b1;
        vid_out_d = data_in;
      end

      if (state_q == IDLE) begin
        count_new = 7'd1;
      end else if (state_q == mode) begin
        if (count_q < MAX_C) begin
          count_new = count_q + 7'd1;
        end else begin
          emit      = 1'b1;
          emit_val  = {is_key, MAX_C};
          count_new = 7'd1;
        end
      end else begin
        // Mode switch closes the previous run/group, whose type is the opposite one.
        emit      = 1'b1;
        emit_val  = {~is_key, count_q};
        count_new = 7'd1;
      end

      state_d = mode;
      count_d = count_new;

      if (emit) begin
        cnt_wr_d  = 1'b1;
        cnt_out_d = emit_val;
      end

      if (last_in) begin
        state_d = IDLE;
        count_d = 7'd0;
        if (emit) begin
          // Strobe slot already used this cycle: defer the flush by one.
          pend_valid_d = 1'b1;
          pend_d       = {is_key, count_new};
        end else begin
          cnt_wr_d  = 1'b1;
          cnt_out_d = {is_key, count_new};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      count_q      <= 7'd0;
      byte_valid_q <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= 8'h00;
      vid_wr_q     <= 1'b0;
      vid_out_q    <= 8'h00;
      cnt_wr_q     <= 1'b0;
      cnt_out_q    <= 8'h00;
    end else if (clk_en) begin
      state_q      <= state_d;
      count_q      <= count_d;
      byte_valid_q <= data_rd;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
      vid_wr_q     <= vid_wr_d;
      vid_out_q    <= vid_out_d;
      cnt_wr_q     <= cnt_wr_d;
      cnt_out_q    <= cnt_out_d;
    end
  end

  // Strobe registers hold across disabled cycles; masking keeps a held strobe from
  // being seen as a write while the clock enable is low.
  assign vid_wr  = vid_wr_q & clk_en;
  assign cnt_wr  = cnt_wr_q & clk_en;
  assign vid_out = vid_out_q;
  assign cnt_out = cnt_out_q;

endmodule

// File: tb/tb_replacer_compact.sv
module tb_replacer_compact;

  logic       clk;
  logic       rst;
  logic       clk_en;
  logic [7:0] data_in;
  logic       last_in;
  logic       data_empty;
  logic       data_rd;
  logic [7:0] vid_out;
  logic       vid_wr;
  logic       vid_afull;
  logic [7:0] cnt_out;
  logic       cnt_wr;
  logic       cnt_afull;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [8:0] fq[$];     // input FIFO model: {last, byte}
  logic [7:0] vq[$];     // captured vid writes
  logic [7:0] cq[$];     // captured cnt writes
  int         ccyc[$];   // cycle of each cnt write
  int         rdc[$];    // cycle of each read

  replacer_compact #(.KEY(8'h00), .MAX_CNT(127)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .data_in(data_in), .last_in(last_in), .data_empty(data_empty), .data_rd(data_rd),
    .vid_out(vid_out), .vid_wr(vid_wr), .vid_afull(vid_afull),
    .cnt_out(cnt_out), .cnt_wr(cnt_wr), .cnt_afull(cnt_afull)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Input FIFO model: non-show-ahead, data appears after the read edge.
  initial begin
    logic rd_s;
    logic [8:0] e;
    data_in = 8'h00; last_in = 1'b0; data_empty = 1'b1;
    forever begin
      @(negedge clk);
      rd_s = data_rd;
      @(posedge clk);
      #1;
      if (rd_s && fq.size() > 0) begin
        e = fq.pop_front();
        data_in = e[7:0];
        last_in = e[8];
      end
      data_empty = (fq.size() == 0);
    end
  end

  // Output monitor.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (data_rd) rdc.push_back(cyc);
      if (vid_wr) vq.push_back(vid_out);
      if (cnt_wr) begin
        cq.push_back(cnt_out);
        ccyc.push_back(cyc);
      end
    end
  end

  task automatic push(input logic [7:0] b, input logic l);
    fq.push_back({l, b});
  endtask

  task automatic clear_mon();
    vq.delete(); cq.delete(); ccyc.delete(); rdc.delete();
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    int quiet = 0;
    while (n < 3000 && !(fq.size() == 0 && quiet >= 6)) begin
      @(negedge clk);
      #1;
      n++;
      quiet = (data_rd || vid_wr || cnt_wr) ? 0 : quiet + 1;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL %s_timeout got fifo_left=%0d exp drained", name, fq.size());
    end
  endtask

  task automatic wait_reads(input int k);
    int n = 0;
    while (n < 500 && rdc.size() < k) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (rdc.size() < k) begin
      errors++;
      $display("FAIL wait_reads got=%0d exp>=%0d", rdc.size(), k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; clk_en = 1'b1; vid_afull = 1'b0; cnt_afull = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (data_rd !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", data_rd); end
    checks++;
    if ({vid_wr, cnt_wr} !== 2'b00) begin errors++; $display("FAIL reset_wr got=%b exp=00", {vid_wr, cnt_wr}); end
    checks++;
    if ({vid_out, cnt_out} !== 16'h0000) begin errors++; $display("FAIL reset_data got=%h exp=0000", {vid_out, cnt_out}); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_literals();
    logic [7:0] ev[$];
    logic [7:0] ec[$];
    bit ok;
    clear_mon();
    push(8'h11, 0); push(8'h22, 0); push(8'h33, 1);
    wait_done("lit");
    ev = '{8'h11, 8'h22, 8'h33};
    ec = '{8'h03};
    ok = (vq.size() == ev.size());
    foreach (ev[i]) if (ok && vq[i] !== ev[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL lit_vid got=%p exp=%p", vq, ev); end
    ok = (cq.size() == ec.size());
    foreach (ec[i]) if (ok && cq[i] !== ec[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL lit_cnt got=%p exp=%p", cq, ec); end
  endtask

  task automatic test_run_then_lit();
    logic [7:0] ev[$];
    logic [7:0] ec[$];
    bit ok;
    clear_mon();
    push(8'h00, 0); push(8'h00, 0); push(8'h00, 0); push(8'h44, 1);
    wait_done("run");
    ev = '{8'h44};
    ec = '{8'h83, 8'h01};
    ok = (vq.size() == ev.size());
    foreach (ev[i]) if (ok && vq[i] !== ev[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL run_vid got=%p exp=%p", vq, ev); end
    ok = (cq.size() == ec.size());
    foreach (ec[i]) if (ok && cq[i] !== ec[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL run_cnt got=%p exp=%p", cq, ec); end
    checks++;
    if (ccyc.size() != 2 || (ccyc[1] - ccyc[0]) != 1) begin
      errors++; $display("FAIL run_cnt_spacing got=%p exp=consecutive", ccyc);
    end
  endtask

  task automatic test_max_rollover();
    logic [7:0] ec[$];
    bit ok;
    clear_mon();
    for (int i = 1; i <= 130; i++) push(8'h00, (i == 130));
    wait_done("max");
    ec = '{8'hFF, 8'h83};
    checks++;
    if (vq.size() != 0) begin errors++; $display("FAIL max_vid got=%0d writes exp=0", vq.size()); end
    ok = (cq.size() == ec.size());
    foreach (ec[i]) if (ok && cq[i] !== ec[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL max_cnt got=%p exp=%p", cq, ec); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ev[$];
    logic [7:0] ec[$];
    bit ok;
    clear_mon();
    push(8'h55, 0); push(8'h00, 1); push(8'h66, 1);
    wait_done("b2b");
    ev = '{8'h55, 8'h66};
    ec = '{8'h01, 8'h81, 8'h01};
    ok = (vq.size() == ev.size());
    foreach (ev[i]) if (ok && vq[i] !== ev[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_vid got=%p exp=%p", vq, ev); end
    ok = (cq.size() == ec.size());
    foreach (ec[i]) if (ok && cq[i] !== ec[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_cnt got=%p exp=%p", cq, ec); end
    checks++;
    if (ccyc.size() < 2 || (ccyc[1] - ccyc[0]) != 1) begin
      errors++; $display("FAIL b2b_cnt_spacing got=%p exp=consecutive", ccyc);
    end
    checks++;
    if (rdc.size() != 3 || (rdc[2] - rdc[1]) != 3) begin
      errors++; $display("FAIL b2b_read_gap got=%p exp=gap of 3 cycles", rdc);
    end
  endtask

  task automatic test_afull();
    logic [7:0] ev[$];
    logic [7:0] ec[$];
    bit ok;
    int base;
    clear_mon();
    for (int i = 1; i <= 20; i++) push(8'(i), (i == 20));
    wait_reads(4);
    @(posedge clk);
    #1;
    vid_afull = 1'b1;
    #1;
    checks++;
    if (data_rd !== 1'b0) begin errors++; $display("FAIL afull_rd got=%b exp=0", data_rd); end
    @(negedge clk);
    #1;
    base = vq.size();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    vid_afull = 1'b0;
    cnt_afull = 1'b1;
    #1;
    checks++;
    if (data_rd !== 1'b0) begin errors++; $display("FAIL cnt_afull_rd got=%b exp=0", data_rd); end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (vq.size() > base + 1) begin errors++; $display("FAIL afull_vid_extra got=%0d exp<=%0d", vq.size(), base + 1); end
    checks++;
    if (rdc.size() != 4) begin errors++; $display("FAIL afull_reads got=%0d exp=4", rdc.size()); end
    @(posedge clk);
    #1;
    cnt_afull = 1'b0;
    wait_done("afull");
    for (int i = 1; i <= 20; i++) ev.push_back(8'(i));
    ec = '{8'h14};
    ok = (vq.size() == ev.size());
    foreach (ev[i]) if (ok && vq[i] !== ev[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL afull_vid got=%p exp=%p", vq, ev); end
    ok = (cq.size() == ec.size());
    foreach (ec[i]) if (ok && cq[i] !== ec[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL afull_cnt got=%p exp=%p", cq, ec); end
  endtask

  task automatic test_clk_en();
    logic [7:0] ev[$];
    logic [7:0] ec[$];
    bit ok;
    clear_mon();
    push(8'hAA, 0); push(8'hBB, 0); push(8'hCC, 1);
    wait_reads(2);
    @(posedge clk);
    #1;
    clk_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({data_rd, vid_wr, cnt_wr} !== 3'b000) begin
        errors++; $display("FAIL clken_frozen got=%b exp=000", {data_rd, vid_wr, cnt_wr});
      end
    end
    @(posedge clk);
    #1;
    clk_en = 1'b1;
    wait_done("clken");
    ev = '{8'hAA, 8'hBB, 8'hCC};
    ec = '{8'h03};
    ok = (vq.size() == ev.size());
    foreach (ev[i]) if (ok && vq[i] !== ev[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL clken_vid got=%p exp=%p", vq, ev); end
    ok = (cq.size() == ec.size());
    foreach (ec[i]) if (ok && cq[i] !== ec[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL clken_cnt got=%p exp=%p", cq, ec); end
  endtask

  task automatic test_reset_mid_run();
    logic [7:0] ev[$];
    logic [7:0] ec[$];
    bit ok;
    clear_mon();
    for (int i = 0; i < 9; i++) push(8'h00, 0);
    wait_done("midrun");
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({data_rd, vid_wr, cnt_wr, vid_out, cnt_out} !== 19'd0) begin
      errors++; $display("FAIL midrun_async got=%b exp=all zero", {data_rd, vid_wr, cnt_wr, vid_out, cnt_out});
    end
    checks++;
    if (cq.size() != 0) begin errors++; $display("FAIL midrun_no_cnt got=%p exp=none", cq); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    clear_mon();
    push(8'h11, 1);
    wait_done("postrst");
    ev = '{8'h11};
    ec = '{8'h01};
    ok = (vq.size() == ev.size());
    foreach (ev[i]) if (ok && vq[i] !== ev[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL postrst_vid got=%p exp=%p", vq, ev); end
    ok = (cq.size() == ec.size());
    foreach (ec[i]) if (ok && cq[i] !== ec[i]) ok = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL postrst_cnt got=%p exp=%p", cq, ec); end
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b1; vid_afull = 1'b0; cnt_afull = 1'b0;
    test_reset();
    test_literals();
    test_run_then_lit();
    test_max_rollover();
    test_back_to_back();
    test_afull();
    test_clk_en();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
